tsc_counter_rf: RTL and testbench
=================================

Name: tsc_counter_rf

Overview:
- Single-register, software-accessible register file holding a 48-bit free-running timestamp counter (tsc_cnt).
- Software side: 64-bit read/write bus with 1-bit address and a one-cycle completion handshake.
- Hardware side: counter value exported continuously, loadable from hardware logic, incremented by a count-up enable.
- Sits between the host register bus and timestamp consumers.

Parameters:
- none (all widths fixed: address 1, data 64, counter 48)

Ports:
- clk  input  1  system clock, all logic on rising edge
- res_n  input  1  asynchronous active-low reset
- address  input  1  register address; 0 = tsc_cnt, 1 = unmapped
- read_en  input  1  software read request, sampled per cycle
- write_en  input  1  software write request, sampled per cycle
- write_data  input  64  software write data; bits [47:0] used
- read_data  output  64  registered read data
- access_complete  output  1  one-cycle pulse acknowledging a read or write
- invalid_address  output  1  flags an access to an unmapped address, valid with access_complete
- tsc_cnt  output  48  current counter value
- tsc_cnt_next  input  48  hardware load value
- tsc_cnt_wen  input  1  hardware load enable
- tsc_cnt_countup  input  1  increment enable

Behaviour:
- Reset (res_n=0, asynchronous): tsc_cnt=0, read_data=0, access_complete=0, invalid_address=0.
  - Inputs may be X during reset; outputs stay at reset values.
- Counter update per rising edge, priority highest first:
  1. Software write: write_en=1 and address=0 -> tsc_cnt <= write_data[47:0]; write_data[63:48] ignored.
  2. Hardware load: tsc_cnt_wen=1 -> tsc_cnt <= tsc_cnt_next.
  3. Count-up: tsc_cnt_countup=1 -> tsc_cnt <= tsc_cnt+1 modulo 2^48 (48'hFFFF_FFFF_FFFF wraps to 0).
  4. Otherwise hold.
- tsc_cnt output is the register itself; no combinational path from inputs.
- Software access:
  - Any cycle with read_en or write_en high is one access.
  - access_complete pulses high exactly one cycle later, for one cycle.
  - Back-to-back requests give back-to-back pulses.
- Reads:
  - address=0: read_data <= {16'b0, tsc_cnt} as sampled in the request cycle (pre-update value).
  - address=1: read_data <= 0.
  - read_data holds its value until the next read completes; writes do not modify it.
- invalid_address:
  - Registered alongside access_complete; 1 iff the completing access targeted address=1.
  - 0 whenever access_complete is 0.
- Writes to address=1: no state change; complete with invalid_address=1.
- read_en and write_en high together: both performed, single access_complete pulse, read returns the pre-write value.
- Software write in the same cycle as tsc_cnt_wen or countup: software value wins; increment is lost that cycle.
- Reset asserted mid-access: pending pulse cancelled, all outputs immediately return to reset values.

Test Plan:
- Reset, then countup=1 held for 20 cycles -> tsc_cnt increments by 1 per cycle, reaching 20; access_complete stays 0.
- Write address=0, write_data=64'hABCD_0000_0000_1234 -> next cycle tsc_cnt=48'h0000_0000_1234, access_complete=1, invalid_address=0; counting continues from there.
- Countup=0, tsc_cnt=5, read address=0 -> one cycle later read_data=64'h5, access_complete=1 for exactly one cycle.
- Read or write address=1 -> access_complete=1, invalid_address=1, read_data=0, tsc_cnt unchanged.
- Load 48'hFFFF_FFFF_FFFE via tsc_cnt_wen, then countup for 3 cycles -> FFFF_FFFF_FFFF, 0, 1; tsc_cnt_wen together with countup loads tsc_cnt_next without increment.
- Software write 48'h10 with tsc_cnt_wen=1 (tsc_cnt_next=48'h20) and countup=1 in the same cycle -> tsc_cnt=48'h10; asserting res_n=0 mid-access immediately clears all outputs.

Source files
------------

// File: rtl/tsc_counter_rf.sv
// ============================================================================
//  Module   : tsc_counter_rf
//  Purpose  : 48-bit free-running timestamp counter behind a 64-bit register bus.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tsc_counter_rf (
  input  logic        clk,
  input  logic        res_n,
  input  logic        address,
  input  logic        read_en,
  input  logic        write_en,
  input  logic [63:0] write_data,
  output logic [63:0] read_data,
  output logic        access_complete,
  output logic        invalid_address,
  output logic [47:0] tsc_cnt,
  input  logic [47:0] tsc_cnt_next,
  input  logic        tsc_cnt_wen,
  input  logic        tsc_cnt_countup
);

  localparam logic [15:0] c_PAD_ZERO = 16'h0000;

  logic [47:0] r_tsc_cnt;
  logic [63:0] r_read_data;
  logic        r_access_complete;
  logic        r_invalid_address;

  logic        w_access;
  logic        w_sw_write;
  logic [47:0] w_tsc_cnt_nxt;

  assign w_access   = read_en | write_en;
  assign w_sw_write = write_en & ~address;

  // Software write beats hardware load, which beats the increment.
  always_comb begin
    w_tsc_cnt_nxt = r_tsc_cnt;
    if (w_sw_write) begin
      w_tsc_cnt_nxt = write_data[47:0];
    end else if (tsc_cnt_wen) begin
      w_tsc_cnt_nxt = tsc_cnt_next;
    end else if (tsc_cnt_countup) begin
      w_tsc_cnt_nxt = r_tsc_cnt + 48'd1;
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_tsc_cnt         <= 48'd0;
      r_read_data       <= 64'd0;
      r_access_complete <= 1'b0;
      r_invalid_address <= 1'b0;
    end else begin
      r_tsc_cnt         <= w_tsc_cnt_nxt;
      r_access_complete <= w_access;
      r_invalid_address <= w_access & address;
      // Reads capture the pre-update counter; writes leave read_data alone.
      if (read_en) begin
        r_read_data <= address ? 64'd0 : {c_PAD_ZERO, r_tsc_cnt};
      end
    end
  end

  assign tsc_cnt         = r_tsc_cnt;
  assign read_data       = r_read_data;
  assign access_complete = r_access_complete;
  assign invalid_address = r_invalid_address;

endmodule

`default_nettype wire

// File: tb/tb_tsc_counter_rf.sv
// ============================================================================
//  Module   : tb_tsc_counter_rf
//  Purpose  : Directed self-checking bench for tsc_counter_rf.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_tsc_counter_rf;

  logic        clk;
  logic        res_n;
  logic        address;
  logic        read_en;
  logic        write_en;
  logic [63:0] write_data;
  logic [63:0] read_data;
  logic        access_complete;
  logic        invalid_address;
  logic [47:0] tsc_cnt;
  logic [47:0] tsc_cnt_next;
  logic        tsc_cnt_wen;
  logic        tsc_cnt_countup;

  int checks = 0;
  int errors = 0;

  tsc_counter_rf dut (
    .clk             (clk),
    .res_n           (res_n),
    .address         (address),
    .read_en         (read_en),
    .write_en        (write_en),
    .write_data      (write_data),
    .read_data       (read_data),
    .access_complete (access_complete),
    .invalid_address (invalid_address),
    .tsc_cnt         (tsc_cnt),
    .tsc_cnt_next    (tsc_cnt_next),
    .tsc_cnt_wen     (tsc_cnt_wen),
    .tsc_cnt_countup (tsc_cnt_countup)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    read_en  = 1'b0;
    write_en = 1'b0;
    tsc_cnt_wen = 1'b0;
  endtask

  initial begin
    res_n = 1'b0;
    address = 1'bx;
    read_en = 1'bx;
    write_en = 1'bx;
    write_data = 'x;
    tsc_cnt_next = 'x;
    tsc_cnt_wen = 1'bx;
    tsc_cnt_countup = 1'bx;
    step();
    step();
    chk("rst_tsc", {16'h0, tsc_cnt}, 64'h0);
    chk("rst_rd", read_data, 64'h0);
    chk("rst_ac", {63'h0, access_complete}, 64'h0);
    chk("rst_inv", {63'h0, invalid_address}, 64'h0);

    // Release reset and count for 20 cycles
    address = 1'b0;
    write_data = 64'h0;
    tsc_cnt_next = 48'h0;
    idle();
    tsc_cnt_countup = 1'b1;
    res_n = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      chk("count", {16'h0, tsc_cnt}, 64'(i));
      chk("count_ac", {63'h0, access_complete}, 64'h0);
    end

    // Software write while counting; upper bits ignored
    write_en = 1'b1;
    write_data = 64'hABCD_0000_0000_1234;
    step();
    write_en = 1'b0;
    chk("swwr_tsc", {16'h0, tsc_cnt}, 64'h1234);
    chk("swwr_ac", {63'h0, access_complete}, 64'h1);
    chk("swwr_inv", {63'h0, invalid_address}, 64'h0);
    step();
    chk("swwr_cont", {16'h0, tsc_cnt}, 64'h1235);
    chk("swwr_ac_end", {63'h0, access_complete}, 64'h0);

    // Stop counting, hardware-load 5, read it back
    tsc_cnt_countup = 1'b0;
    tsc_cnt_wen = 1'b1;
    tsc_cnt_next = 48'h5;
    step();
    tsc_cnt_wen = 1'b0;
    chk("hwld_tsc", {16'h0, tsc_cnt}, 64'h5);
    read_en = 1'b1;
    step();
    read_en = 1'b0;
    chk("rd0_data", read_data, 64'h5);
    chk("rd0_ac", {63'h0, access_complete}, 64'h1);
    chk("rd0_inv", {63'h0, invalid_address}, 64'h0);
    step();
    chk("rd0_ac_pulse", {63'h0, access_complete}, 64'h0);
    chk("rd0_hold", read_data, 64'h5);

    // Write to unmapped address: no state change, read_data untouched
    address = 1'b1;
    write_en = 1'b1;
    write_data = 64'h99;
    step();
    write_en = 1'b0;
    chk("wr1_ac", {63'h0, access_complete}, 64'h1);
    chk("wr1_inv", {63'h0, invalid_address}, 64'h1);
    chk("wr1_tsc", {16'h0, tsc_cnt}, 64'h5);
    chk("wr1_rd", read_data, 64'h5);

    // Read of unmapped address returns zero
    read_en = 1'b1;
    step();
    read_en = 1'b0;
    chk("rd1_ac", {63'h0, access_complete}, 64'h1);
    chk("rd1_inv", {63'h0, invalid_address}, 64'h1);
    chk("rd1_rd", read_data, 64'h0);
    chk("rd1_tsc", {16'h0, tsc_cnt}, 64'h5);
    step();
    chk("idle_ac", {63'h0, access_complete}, 64'h0);
    chk("idle_inv", {63'h0, invalid_address}, 64'h0);

    // Simultaneous read and write: read returns pre-write value, single pulse
    address = 1'b0;
    read_en = 1'b1;
    write_en = 1'b1;
    write_data = 64'h7;
    step();
    idle();
    chk("rw_rd", read_data, 64'h5);
    chk("rw_tsc", {16'h0, tsc_cnt}, 64'h7);
    chk("rw_ac", {63'h0, access_complete}, 64'h1);
    step();
    chk("rw_ac_single", {63'h0, access_complete}, 64'h0);

    // Back-to-back reads give back-to-back pulses
    read_en = 1'b1;
    step();
    chk("b2b_ac0", {63'h0, access_complete}, 64'h1);
    step();
    read_en = 1'b0;
    chk("b2b_ac1", {63'h0, access_complete}, 64'h1);
    chk("b2b_rd", read_data, 64'h7);
    step();
    chk("b2b_ac_end", {63'h0, access_complete}, 64'h0);

    // Hardware load with countup: load wins, then wrap through zero
    tsc_cnt_wen = 1'b1;
    tsc_cnt_countup = 1'b1;
    tsc_cnt_next = 48'hFFFF_FFFF_FFFE;
    step();
    tsc_cnt_wen = 1'b0;
    chk("ld_noinc", {16'h0, tsc_cnt}, 64'h0000_FFFF_FFFF_FFFE);
    step();
    chk("wrap_ffff", {16'h0, tsc_cnt}, 64'h0000_FFFF_FFFF_FFFF);
    step();
    chk("wrap_zero", {16'h0, tsc_cnt}, 64'h0);
    step();
    chk("wrap_one", {16'h0, tsc_cnt}, 64'h1);

    // Software write beats hardware load and countup
    write_en = 1'b1;
    write_data = 64'h10;
    tsc_cnt_wen = 1'b1;
    tsc_cnt_next = 48'h20;
    step();
    idle();
    tsc_cnt_countup = 1'b0;
    chk("prio_sw", {16'h0, tsc_cnt}, 64'h10);

    // Reset mid-access clears outputs immediately and cancels pending pulse
    read_en = 1'b1;
    step();
    chk("pre_rst_ac", {63'h0, access_complete}, 64'h1);
    chk("pre_rst_rd", read_data, 64'h10);
    #2;
    res_n = 1'b0;
    #1;
    chk("async_tsc", {16'h0, tsc_cnt}, 64'h0);
    chk("async_rd", read_data, 64'h0);
    chk("async_ac", {63'h0, access_complete}, 64'h0);
    chk("async_inv", {63'h0, invalid_address}, 64'h0);
    step();
    chk("rst_pend_ac", {63'h0, access_complete}, 64'h0);
    chk("rst_pend_rd", read_data, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
